fetch_ctrl: RTL

Instruction-fetch sequencer for the pipelined ARM core. Owns the PC and drives the byte address of the combinational instruction ROM (word-aligned, 32-bit reads). Captures the returned word into the IF/ID register, and handles start, stall, branch redirect, and out-of-bounds/misaligned fetch faults. Sits between the ROM and the decode stage; the hazard unit supplies stall, and the branch unit supplies redirect.

---
 rtl/fetch_ctrl_if.sv | 28 ++
 rtl/fetch_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: control inputs from the hazard and branch units, the
// combinational ROM port, and the IF/ID register outputs toward decode.
interface fetch_ctrl_if;
  logic        start;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_valid;
  logic        fault;
  logic        busy;
  logic [31:0] fetch_count;

  // Fetch sequencer side
  modport slave (
    input  start, stall, redirect, redirect_target, imem_instr,
    output imem_addr, if_instr, if_pc, if_valid, fault, busy, fetch_count
  );

  // Environment side: core control, ROM and decode stage
  modport master (
    output start, stall, redirect, redirect_target, imem_instr,
    input  imem_addr, if_instr, if_pc, if_valid, fault, busy, fetch_count
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM byte address,
// captures fetched words into the IF/ID register and traps bad fetches.
module fetch_ctrl #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [31:0] NOP_WORD = 32'hD503201F
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic [1:0]  r_state;
  logic [63:0] r_pc;
  logic [31:0] r_if_instr;
  logic [63:0] r_if_pc;
  logic        r_if_valid;
  logic        r_fault;
  logic [31:0] r_fetch_count;

  logic [64:0] w_pc_end;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_bad_pc;

  // Bad-address detection; the last byte address is formed in 65 bits so a
  // PC near 2^64 cannot wrap back into range
  always_comb begin
    w_pc_end       = {1'b0, r_pc} + 65'd3;
    w_misaligned   = (r_pc[1:0] != 2'b00);
    w_out_of_range = (w_pc_end >= 65'(MEM_SIZE));
    w_bad_pc       = w_misaligned || w_out_of_range;
  end

  // Sequencer state, PC and IF/ID register; redirect > stall > fault > advance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_if_instr    <= NOP_WORD;
      r_if_pc       <= '0;
      r_if_valid    <= 1'b0;
      r_fault       <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pc <= RESET_PC;
          if (bus.start) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.redirect) begin
            r_pc       <= bus.redirect_target;
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_WORD;
          end else if (bus.stall) begin
            r_pc <= r_pc;
          end else if (w_bad_pc) begin
            r_state    <= S_FAULT;
            r_fault    <= 1'b1;
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_WORD;
          end else begin
            r_if_instr <= bus.imem_instr;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b1;
            r_pc       <= r_pc + 64'd4;
            if (r_fetch_count != '1) begin
              r_fetch_count <= r_fetch_count + 32'd1;
            end
          end
        end
        S_FAULT: begin
          r_fault    <= 1'b1;
          r_if_valid <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_pc    <= RESET_PC;
        end
      endcase
    end
  end

  // Output drive; the ROM address is the PC register itself
  always_comb begin
    bus.imem_addr   = r_pc;
    bus.if_instr    = r_if_instr;
    bus.if_pc       = r_if_pc;
    bus.if_valid    = r_if_valid;
    bus.fault       = r_fault;
    bus.busy        = (r_state == S_RUN);
    bus.fetch_count = r_fetch_count;
  end

endmodule
